clock_setup_controller: RTL and testbench

- Sequences the digital clock between run display and time-setting.
- Drives the display driver's `mode`, `location` and digit inputs.
- Owns the edit registers for hours and minutes, and issues a one-cycle load strobe to the timekeeper on commit.
- Generates the blink phase for the digit being edited and a free-running digit-scan tick.

---
 rtl/clock_setup_controller.sv | 198 +++++++++++++++++++
 tb/tb_clock_setup_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_setup_controller.sv
// Run/set sequencer for the digital clock: owns the hour/minute edit registers,
// drives the display driver, and strobes a commit into the timekeeper.
module clock_setup_controller #(
    parameter int BLINK_DIV = 25000000,
    parameter int SCAN_DIV  = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic [3:0] cur_hu,
    input  logic [3:0] cur_hl,
    input  logic [3:0] cur_mu,
    input  logic [3:0] cur_ml,
    output logic [1:0] mode,
    output logic [1:0] location,
    output logic [3:0] disp_hu,
    output logic [3:0] disp_hl,
    output logic [3:0] disp_mu,
    output logic [3:0] disp_ml,
    output logic       blink_on,
    output logic       scan_tick,
    output logic       load,
    output logic [3:0] set_hu,
    output logic [3:0] set_hl,
    output logic [3:0] set_mu,
    output logic [3:0] set_ml
);

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_SETUP = 2'b00;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_HU = 3'd1,
        ST_SET_HL = 3'd2,
        ST_SET_MU = 3'd3,
        ST_SET_ML = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [1:0]         location_q;
    logic               load_q;
    logic [3:0]         edit_hu_q, edit_hl_q, edit_mu_q, edit_ml_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_on_q;
    logic [SCAN_W-1:0]  scan_cnt_q;
    logic               scan_tick_q;

    logic [3:0] hu_inc_d, hl_inc_d, mu_inc_d, ml_inc_d, hl_max, hl_after_hu_d;

    // Wrapping increments; anything at or beyond the digit's maximum (including
    // out-of-range values copied from the timekeeper) goes back to 0.
    always_comb begin
        hu_inc_d      = (edit_hu_q >= 4'd2) ? 4'd0 : edit_hu_q + 4'd1;
        hl_max        = (edit_hu_q < 4'd2) ? 4'd9 : 4'd3;
        hl_inc_d      = (edit_hl_q >= hl_max) ? 4'd0 : edit_hl_q + 4'd1;
        mu_inc_d      = (edit_mu_q >= 4'd5) ? 4'd0 : edit_mu_q + 4'd1;
        ml_inc_d      = (edit_ml_q >= 4'd9) ? 4'd0 : edit_ml_q + 4'd1;
        hl_after_hu_d = (hu_inc_d == 4'd2 && edit_hl_q > 4'd3) ? 4'd0 : edit_hl_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            mode_q      <= MODE_RUN;
            location_q  <= 2'd0;
            load_q      <= 1'b0;
            edit_hu_q   <= 4'd0;
            edit_hl_q   <= 4'd0;
            edit_mu_q   <= 4'd0;
            edit_ml_q   <= 4'd0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    blink_cnt_q <= '0;
                    blink_on_q  <= 1'b1;
                    if (btn_mode) begin
                        state_q    <= ST_SET_HU;
                        mode_q     <= MODE_SETUP;
                        location_q <= 2'd0;
                        edit_hu_q  <= cur_hu;
                        edit_hl_q  <= cur_hl;
                        edit_mu_q  <= cur_mu;
                        edit_ml_q  <= cur_ml;
                    end
                end
                ST_SET_HU, ST_SET_HL, ST_SET_MU, ST_SET_ML: begin
                    if (btn_mode) begin
                        state_q     <= ST_RUN;
                        mode_q      <= MODE_RUN;
                        location_q  <= 2'd0;
                        blink_cnt_q <= '0;
                        blink_on_q  <= 1'b1;
                    end else if (btn_next) begin
                        blink_cnt_q <= '0;
                        blink_on_q  <= 1'b1;
                        case (state_q)
                            ST_SET_HU: state_q <= ST_SET_HL;
                            ST_SET_HL: state_q <= ST_SET_MU;
                            ST_SET_MU: state_q <= ST_SET_ML;
                            default:   state_q <= ST_COMMIT;
                        endcase
                        if (state_q == ST_SET_ML) begin
                            load_q     <= 1'b1;
                            mode_q     <= MODE_RUN;
                            location_q <= 2'd0;
                        end else begin
                            location_q <= location_q + 2'd1;
                        end
                    end else begin
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_q <= '0;
                            blink_on_q  <= ~blink_on_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
                        end
                        if (btn_inc) begin
                            case (state_q)
                                ST_SET_HU: begin
                                    edit_hu_q <= hu_inc_d;
                                    edit_hl_q <= hl_after_hu_d;
                                end
                                ST_SET_HL: edit_hl_q <= hl_inc_d;
                                ST_SET_MU: edit_mu_q <= mu_inc_d;
                                default:   edit_ml_q <= ml_inc_d;
                            endcase
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q     <= ST_RUN;
                    mode_q      <= MODE_RUN;
                    location_q  <= 2'd0;
                    blink_cnt_q <= '0;
                    blink_on_q  <= 1'b1;
                end
                default: begin
                    state_q     <= ST_RUN;
                    mode_q      <= MODE_RUN;
                    location_q  <= 2'd0;
                    blink_cnt_q <= '0;
                    blink_on_q  <= 1'b1;
                end
            endcase
        end
    end

    // Free-running scan divider; the tick lands on the cycle after the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            scan_tick_q <= 1'b0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q  <= '0;
            scan_tick_q <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_q + SCAN_W'(1);
            scan_tick_q <= 1'b0;
        end
    end

    // Outside RUN (edit and the commit cycle) the display shows the edit registers.
    always_comb begin
        if (state_q == ST_RUN) begin
            disp_hu = cur_hu;
            disp_hl = cur_hl;
            disp_mu = cur_mu;
            disp_ml = cur_ml;
        end else begin
            disp_hu = edit_hu_q;
            disp_hl = edit_hl_q;
            disp_mu = edit_mu_q;
            disp_ml = edit_ml_q;
        end
    end

    assign mode      = mode_q;
    assign location  = location_q;
    assign load      = load_q;
    assign blink_on  = blink_on_q;
    assign scan_tick = scan_tick_q;
    assign set_hu    = edit_hu_q;
    assign set_hl    = edit_hl_q;
    assign set_mu    = edit_mu_q;
    assign set_ml    = edit_ml_q;

endmodule

// File: tb/tb_clock_setup_controller.sv
// Bench for clock_setup_controller: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized buttons/time.
module tb_clock_setup_controller;

    localparam int BLINK_DIV = 4;
    localparam int SCAN_DIV  = 3;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_next, btn_inc;
    logic [3:0] cur_hu, cur_hl, cur_mu, cur_ml;
    logic [1:0] mode, location;
    logic [3:0] disp_hu, disp_hl, disp_mu, disp_ml;
    logic       blink_on, scan_tick, load;
    logic [3:0] set_hu, set_hl, set_mu, set_ml;

    clock_setup_controller #(.BLINK_DIV(BLINK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .cur_hu(cur_hu), .cur_hl(cur_hl), .cur_mu(cur_mu), .cur_ml(cur_ml),
        .mode(mode), .location(location),
        .disp_hu(disp_hu), .disp_hl(disp_hl), .disp_mu(disp_mu), .disp_ml(disp_ml),
        .blink_on(blink_on), .scan_tick(scan_tick), .load(load),
        .set_hu(set_hu), .set_hl(set_hl), .set_mu(set_mu), .set_ml(set_ml)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_state: 0 = run, 1..4 = editing digit (m_state-1), 5 = commit cycle
    int         m_state = 0;
    int         m_age   = 0;
    int         m_cyc   = 0;
    bit         m_valid = 0;
    logic [3:0] m_edit [4];
    logic [3:0] s_cur  [4];
    bit         s_rst, s_mode, s_next, s_inc;
    logic [15:0] exp_q[$];
    logic [15:0] exp_word;

    function automatic void bump(input int d);
        logic [3:0] lim [4];
        lim = '{4'd2, (m_edit[0] < 4'd2) ? 4'd9 : 4'd3, 4'd5, 4'd9};
        if (m_edit[d] >= lim[d]) m_edit[d] = 4'd0;
        else m_edit[d] = m_edit[d] + 4'd1;
        if (d == 0 && m_edit[0] == 4'd2 && m_edit[1] > 4'd3) m_edit[1] = 4'd0;
    endfunction

    always @(posedge clk) begin
        s_rst = rst; s_mode = btn_mode; s_next = btn_next; s_inc = btn_inc;
        s_cur = '{cur_hu, cur_hl, cur_mu, cur_ml};
        if (s_rst) begin
            m_state = 0; m_age = 0; m_cyc = 0; m_valid = 1;
            m_edit = '{4'd0, 4'd0, 4'd0, 4'd0};
            exp_q.delete();
        end else if (m_valid) begin
            m_cyc++;
            if (m_state == 0) begin
                if (s_mode) begin m_state = 1; m_edit = s_cur; m_age = 0; end
            end else if (m_state == 5) begin
                m_state = 0;
            end else if (s_mode) begin
                m_state = 0; m_age = 0;
            end else if (s_next) begin
                m_age = 0;
                m_state++;
                if (m_state == 5) exp_q.push_back({m_edit[0], m_edit[1], m_edit[2], m_edit[3]});
            end else begin
                m_age++;
                if (s_inc) bump(m_state - 1);
            end
        end
        #1;
        if (m_valid) begin
            bit in_set;
            in_set = (m_state >= 1 && m_state <= 4);
            check("mode", mode, in_set ? 0 : 1);
            check("location", location, in_set ? m_state - 1 : 0);
            check("load", load, (m_state == 5) ? 1 : 0);
            check("blink_on", blink_on, in_set ? (((m_age / BLINK_DIV) % 2 == 0) ? 1 : 0) : 1);
            check("scan_tick", scan_tick, (m_cyc > 0 && m_cyc % SCAN_DIV == 0) ? 1 : 0);
            check("set", {set_hu, set_hl, set_mu, set_ml},
                  {m_edit[0], m_edit[1], m_edit[2], m_edit[3]});
            if (m_state == 0)
                check("disp_run", {disp_hu, disp_hl, disp_mu, disp_ml},
                      {s_cur[0], s_cur[1], s_cur[2], s_cur[3]});
            else
                check("disp_edit", {disp_hu, disp_hl, disp_mu, disp_ml},
                      {m_edit[0], m_edit[1], m_edit[2], m_edit[3]});
            if (load) begin
                if (exp_q.size() == 0) check("load_unexpected", 1, 0);
                else begin
                    exp_word = exp_q.pop_front();
                    check("load_value", {set_hu, set_hl, set_mu, set_ml}, exp_word);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse(input bit m, input bit n, input bit i);
        btn_mode = m; btn_next = n; btn_inc = i;
        @(negedge clk);
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic set_cur(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        cur_hu = a; cur_hl = b; cur_mu = c; cur_ml = d;
    endtask

    function automatic int disp_word();
        return {disp_hu, disp_hl, disp_mu, disp_ml};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int ticks;
        rst = 1'b1; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        set_cur(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("lit_rst_mode", mode, 1);
        check("lit_rst_loc", location, 0);
        check("lit_rst_load", load, 0);
        check("lit_rst_blink", blink_on, 1);
        check("lit_rst_disp", disp_word(), 16'h1234);
        ticks = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            ticks += int'(scan_tick);
        end
        check("lit_scan_ticks", ticks, 3);

        // walk all digits and commit unchanged
        pulse(1, 0, 0);
        check("lit_enter_mode", mode, 0);
        check("lit_enter_loc", location, 0);
        check("lit_enter_disp", disp_word(), 16'h1234);
        for (int k = 1; k < 4; k++) begin
            pulse(0, 1, 0);
            check("lit_walk_loc", location, k);
        end
        pulse(0, 1, 0);
        check("lit_commit_load", load, 1);
        check("lit_commit_set", {set_hu, set_hl, set_mu, set_ml}, 16'h1234);
        @(negedge clk);
        check("lit_after_load", load, 0);
        check("lit_after_mode", mode, 1);

        // increment ranges from zero
        set_cur(4'd0, 4'd0, 4'd0, 4'd0);
        pulse(1, 0, 0);
        pulse(0, 0, 1); check("lit_hu_1", disp_hu, 1);
        pulse(0, 0, 1); check("lit_hu_2", disp_hu, 2);
        pulse(0, 0, 1); check("lit_hu_wrap", disp_hu, 0);
        pulse(0, 1, 0);
        repeat (9) pulse(0, 0, 1);
        check("lit_hl_9", disp_hl, 9);
        pulse(0, 1, 0);
        repeat (5) pulse(0, 0, 1);
        check("lit_mu_5", disp_mu, 5);
        pulse(0, 0, 1); check("lit_mu_wrap", disp_mu, 0);
        pulse(1, 0, 0);

        // hours clamp, then abort with coinciding buttons
        set_cur(4'd1, 4'd9, 4'd0, 4'd0);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        check("lit_clamp", {disp_hu, disp_hl}, 8'h20);
        pulse(0, 1, 0);
        pulse(0, 0, 1); check("lit_hl23_1", disp_hl, 1);
        pulse(0, 0, 1); check("lit_hl23_2", disp_hl, 2);
        pulse(0, 0, 1); check("lit_hl23_3", disp_hl, 3);
        pulse(0, 0, 1); check("lit_hl23_wrap", disp_hl, 0);
        pulse(0, 1, 0);
        check("lit_in_mu", location, 2);
        pulse(1, 1, 0);
        check("lit_abort_mode", mode, 1);
        check("lit_abort_load", load, 0);
        check("lit_abort_disp", disp_word(), 16'h1900);

        // out-of-range live value is shown, first inc zeroes it
        set_cur(4'd7, 4'd0, 4'd0, 4'd0);
        pulse(1, 0, 0);
        check("lit_oor_show", disp_hu, 7);
        pulse(0, 0, 1);
        check("lit_oor_inc", disp_hu, 0);
        pulse(1, 0, 0);

        // blink phase while idle in SET_HL, restart on advance, reset mid-edit
        set_cur(4'd0, 4'd5, 4'd0, 4'd0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3)  check("lit_blink_a3", blink_on, 1);
            if (k == 4)  check("lit_blink_a4", blink_on, 0);
            if (k == 8)  check("lit_blink_a8", blink_on, 1);
            if (k == 12) check("lit_blink_a12", blink_on, 0);
        end
        pulse(0, 1, 0);
        check("lit_blink_restart", blink_on, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("lit_mid_rst_mode", mode, 1);
        check("lit_mid_rst_loc", location, 0);
        check("lit_mid_rst_load", load, 0);
        check("lit_mid_rst_blink", blink_on, 1);
        check("lit_mid_rst_tick", scan_tick, 0);
        check("lit_mid_rst_set", {set_hu, set_hl, set_mu, set_ml}, 0);
        check("lit_mid_rst_disp", disp_word(), 16'h0500);

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            btn_mode = ($urandom_range(0, 15) == 0);
            btn_next = ($urandom_range(0, 5) == 0);
            btn_inc  = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 49) == 0)
                set_cur(4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 7)), 4'($urandom_range(0, 12)));
            @(negedge clk);
        end
        rst = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        check("load_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
